ahb_arbiter: RTL



---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_arbiter_rr_pick.sv | 29 ++
 rtl/ahb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB arbitration definitions: transfer-type codes, arbiter state encoding
// and a one-hot to index helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Sized for up to 8 masters; callers zero-extend narrower vectors.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping,
// so the pointer's own bit has the lowest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int MW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [MW-1:0] ptr_i,
  output logic [MW-1:0] winner_o,
  output logic          any_req_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    logic [IW-1:0] j;
    j         = '0;
    winner_o  = '0;
    any_req_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!any_req_o && req_i[j]) begin
        winner_o  = MW'(j);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with burst and locked-transfer hold-off.
//   state  | meaning
//   ARB    | free to re-arbitrate on the next hready edge
//   BURST  | address-phase owner is mid-burst (SEQ/BUSY)
//   LOCKED | address-phase owner holds hlock
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk_i,
  input  logic                   hreset_i,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  input  logic [NUM_MASTERS-1:0] hlock_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hready_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  output logic [MW-1:0]          hmaster_o,
  output logic [MW-1:0]          hmaster_d_o,
  output logic                   hmastlock_o
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [MW-1:0]          hmaster_q;
  logic [MW-1:0]          hmaster_dp_q;
  logic                   hmastlock_q;
  logic [MW-1:0]          rr_ptr_q;

  logic          in_burst;
  logic          own_lock;
  logic          grant_lock;
  logic [MW-1:0] grant_idx;
  logic [MW-1:0] winner;
  logic          any_req;
  logic          arb_en;

  assign in_burst  = (htrans_i == HTRANS_SEQ) || (htrans_i == HTRANS_BUSY);
  assign grant_idx = MW'(onehot2idx(8'(hgrant_q)));

  // Explicit lookups keep indexing width-safe for any MW >= clog2(NUM_MASTERS).
  always_comb begin
    own_lock   = 1'b0;
    grant_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster_q == MW'(i)) own_lock   = hlock_i[i];
      if (grant_idx == MW'(i)) grant_lock = hlock_i[i];
    end
  end

  assign arb_en = (state_q == ARB) && !in_burst && !own_lock;

  rr_pick #(
    .N  (NUM_MASTERS),
    .MW (MW)
  ) u_rr_pick (
    .req_i     (hbusreq_i),
    .ptr_i     (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q      <= ARB;
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_IDX;
      hmaster_dp_q <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      rr_ptr_q     <= DEF_IDX;
    end else if (hready_i) begin
      hmaster_q    <= grant_idx;
      hmastlock_q  <= grant_lock;
      hmaster_dp_q <= hmaster_q;
      if (arb_en) begin
        if (any_req) begin
          hgrant_q <= NUM_MASTERS'(1) << winner;
          rr_ptr_q <= winner;
        end else begin
          hgrant_q <= DEF_GRANT;
        end
      end
      unique case (state_q)
        ARB: begin
          if (own_lock)      state_q <= LOCKED;
          else if (in_burst) state_q <= BURST;
        end
        BURST: begin
          if (own_lock)       state_q <= LOCKED;
          else if (!in_burst) state_q <= ARB;
        end
        LOCKED: begin
          if (!own_lock) state_q <= in_burst ? BURST : ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign hgrant_o    = hgrant_q;
  assign hmaster_o   = hmaster_q;
  assign hmaster_d_o = hmaster_dp_q;
  assign hmastlock_o = hmastlock_q;

endmodule
